// File: rtl/pkt_task_sched_pkg.sv
// Shared types for the per-flow task scheduler: flow configuration, committed
// task record and task-stage FSM states.
package pkt_task_sched_pkg;

    localparam int CNT_W = 32;  // stored budget width; top CNT_WIDTH must not exceed it
    localparam int STR_W = 8;   // stored flow index width; covers up to 256 flows

    typedef struct packed {
        logic             en;
        logic             unlimited;
        logic [15:0]      size;
        logic [CNT_W-1:0] remaining;
    } flow_cfg_t;

    typedef struct packed {
        logic [STR_W-1:0] str;
        logic [15:0]      size;
    } task_t;

    typedef enum logic {ST_EMPTY, ST_FULL} stage_st_t;

    function automatic logic flow_eligible(input flow_cfg_t c);
        return c.en && (c.size != '0) && (c.unlimited || (c.remaining != '0));
    endfunction

endpackage

// File: rtl/pkt_task_sched_rr_arbiter.sv
// Round-robin arbiter: combinational search starting after the last winner,
// with the pointer register advanced to the winner on each accepted grant.
module rr_arbiter #(
    parameter int N = 16,
    parameter int W = (N == 1) ? 1 : $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] j;
    logic         found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = W'((int'(ptr_q) + k) % N);
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_o = j;
            end
        end
        if (found)
            gnt_o[idx_o] = 1'b1;
    end

    // Reset to the last flow so flow 0 is the first to win.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ptr_q <= W'(N - 1);
        else if (advance_i)
            ptr_q <= idx_o;
    end

endmodule

// File: rtl/pkt_task_sched.sv
// Per-flow task scheduler feeding the packet generator's show-ahead task port.
// Optional per-flow consumed-task counters under PKT_TASK_SCHED_STAT_EN.
module pkt_task_sched
    import pkt_task_sched_pkg::*;
#(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
`ifdef PKT_TASK_SCHED_STAT_EN
    input  logic [FLOW_CNT_WIDTH-1:0] stat_flow_i,
    output logic [31:0]               stat_pkt_cnt_o,
`endif
    input  logic                      run_i,
    input  logic                      cfg_wr_i,
    input  logic [FLOW_CNT_WIDTH-1:0] cfg_flow_i,
    input  logic                      cfg_en_i,
    input  logic [15:0]               cfg_size_i,
    input  logic [CNT_WIDTH-1:0]      cfg_pkt_cnt_i,
    output logic [FLOW_CNT_WIDTH-1:0] pkt_task_str_o,
    output logic [15:0]               pkt_task_size_o,
    output logic                      pkt_task_val_o,
    input  logic                      pkt_task_rd_req_i,
    output logic [FLOW_CNT-1:0]       flow_done_o,
    output logic                      busy_o
);

    flow_cfg_t                 cfg_q [FLOW_CNT];
    logic [FLOW_CNT-1:0]       elig;
    logic [FLOW_CNT-1:0]       gnt_oh;
    logic [FLOW_CNT_WIDTH-1:0] win;
    logic                      grant;
    stage_st_t                 st_q, st_d;
    task_t                     stage_q;
    logic                      unused_str;

    always_comb begin
        elig = '0;
        for (int i = 0; i < FLOW_CNT; i++)
            elig[i] = flow_eligible(cfg_q[i]);
    end

    assign grant = run_i && (elig != '0) && ((st_q == ST_EMPTY) || pkt_task_rd_req_i);

    rr_arbiter #(.N(FLOW_CNT), .W(FLOW_CNT_WIDTH)) u_arb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (elig),
        .advance_i (grant),
        .gnt_o     (gnt_oh),
        .idx_o     (win)
    );

    // Budget is charged at grant; a same-cycle config write to that flow wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FLOW_CNT; i++)
                cfg_q[i] <= '0;
        end else begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                if (grant && gnt_oh[i] && !cfg_q[i].unlimited)
                    cfg_q[i].remaining <= cfg_q[i].remaining - CNT_W'(1);
                if (cfg_wr_i && (cfg_flow_i == FLOW_CNT_WIDTH'(i)))
                    cfg_q[i] <= '{en:        cfg_en_i,
                                  unlimited: (cfg_pkt_cnt_i == '0),
                                  size:      cfg_size_i,
                                  remaining: CNT_W'(cfg_pkt_cnt_i)};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            st_q <= ST_EMPTY;
        else
            st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: if (grant) st_d = ST_FULL;
            ST_FULL:  if (pkt_task_rd_req_i && !grant) st_d = ST_EMPTY;
            default:  st_d = ST_EMPTY;
        endcase
    end

    // The stage latches the pre-write size so a committed task is never altered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stage_q <= '0;
        else if (grant)
            stage_q <= '{str: STR_W'(win), size: cfg_q[win].size};
    end

    assign pkt_task_val_o  = (st_q == ST_FULL);
    assign pkt_task_str_o  = stage_q.str[FLOW_CNT_WIDTH-1:0];
    assign pkt_task_size_o = stage_q.size;
    assign busy_o          = pkt_task_val_o || (elig != '0);
    assign unused_str      = ^stage_q.str;

    always_comb begin
        flow_done_o = '0;
        for (int i = 0; i < FLOW_CNT; i++)
            flow_done_o[i] = cfg_q[i].en && !cfg_q[i].unlimited && (cfg_q[i].remaining == '0)
                             && !(pkt_task_val_o && (stage_q.str == STR_W'(i)));
    end

`ifdef PKT_TASK_SCHED_STAT_EN
    logic [31:0] stat_cnt [FLOW_CNT];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FLOW_CNT; i++)
                stat_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                if (cfg_wr_i && (cfg_flow_i == FLOW_CNT_WIDTH'(i)))
                    stat_cnt[i] <= '0;
                else if (pkt_task_rd_req_i && pkt_task_val_o && (stage_q.str == STR_W'(i)))
                    stat_cnt[i] <= stat_cnt[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stat_pkt_cnt_o <= '0;
        else
            stat_pkt_cnt_o <= stat_cnt[stat_flow_i];
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_n_i)
            assert (!(pkt_task_rd_req_i && !pkt_task_val_o))
            else $warning("pkt_task_rd_req_i with empty task stage ignored");
    end
`endif

endmodule

// File: tb/tb_pkt_task_sched.sv
// Directed bench for pkt_task_sched; inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_pkt_task_sched;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        cfg_wr;
    logic [3:0]  cfg_flow;
    logic        cfg_en;
    logic [15:0] cfg_size;
    logic [31:0] cfg_cnt;
    logic [3:0]  str;
    logic [15:0] size;
    logic        val;
    logic        rd_req;
    logic [15:0] done;
    logic        busy;
`ifdef PKT_TASK_SCHED_STAT_EN
    logic [3:0]  stat_flow;
    logic [31:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pkt_task_sched #(.FLOW_CNT(16), .CNT_WIDTH(32)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
`ifdef PKT_TASK_SCHED_STAT_EN
        .stat_flow_i       (stat_flow),
        .stat_pkt_cnt_o    (stat_cnt),
`endif
        .run_i             (run),
        .cfg_wr_i          (cfg_wr),
        .cfg_flow_i        (cfg_flow),
        .cfg_en_i          (cfg_en),
        .cfg_size_i        (cfg_size),
        .cfg_pkt_cnt_i     (cfg_cnt),
        .pkt_task_str_o    (str),
        .pkt_task_size_o   (size),
        .pkt_task_val_o    (val),
        .pkt_task_rd_req_i (rd_req),
        .flow_done_o       (done),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0; run = 1'b0; cfg_wr = 1'b0; rd_req = 1'b0;
        cfg_flow = '0; cfg_en = 1'b0; cfg_size = '0; cfg_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [3:0] f, input logic en, input logic [15:0] sz,
                             input logic [31:0] cnt);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_flow = f; cfg_en = en; cfg_size = sz; cfg_cnt = cnt;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; cfg_wr = 1'b0; rd_req = 1'b0;
        cfg_flow = '0; cfg_en = 1'b0; cfg_size = '0; cfg_cnt = '0;
`ifdef PKT_TASK_SCHED_STAT_EN
        stat_flow = '0;
`endif
        #3;
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b expected 0", val); end
        checks++; if (str !== 4'd0) begin errors++; $display("FAIL reset_str: got %0d expected 0", str); end
        checks++; if (size !== 16'd0) begin errors++; $display("FAIL reset_size: got %0d expected 0", size); end
        checks++; if (done !== 16'h0) begin errors++; $display("FAIL reset_done: got %h expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_flow();
        run = 1'b1;
        cfg_write(4'd3, 1'b1, 16'd64, 32'd2);
        @(negedge clk);
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL single_latency: val got %b expected 0", val); end
        @(negedge clk);
        checks++; if (val !== 1'b1 || str !== 4'd3 || size !== 16'd64) begin errors++;
            $display("FAIL single_task1: val %b str %0d size %0d expected 1/3/64", val, str, size); end
        rd_req = 1'b1;
        @(negedge clk);
        checks++; if (val !== 1'b1 || str !== 4'd3 || size !== 16'd64) begin errors++;
            $display("FAIL single_task2: val %b str %0d size %0d expected 1/3/64", val, str, size); end
        checks++; if (done[3] !== 1'b0) begin errors++; $display("FAIL single_done_in_stage: got %b expected 0", done[3]); end
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL single_end_val: got %b expected 0", val); end
        checks++; if (done[3] !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done[3]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
        run = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_str [6] = '{0, 1, 5, 0, 1, 5};
        int exp_sz  [6] = '{10, 20, 50, 10, 20, 50};
        apply_reset();
        cfg_write(4'd0, 1'b1, 16'd10, 32'd0);
        cfg_write(4'd1, 1'b1, 16'd20, 32'd0);
        cfg_write(4'd5, 1'b1, 16'd50, 32'd0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (val !== 1'b1 || str !== 4'(exp_str[i]) || size !== 16'(exp_sz[i])) begin errors++;
                $display("FAIL rr_seq%0d: val %b str %0d size %0d expected 1/%0d/%0d",
                         i, val, str, size, exp_str[i], exp_sz[i]); end
            rd_req = 1'b1;
        end
        run = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL rr_stop: val got %b expected 0", val); end
    endtask

    task automatic test_stall();
        int n;
        apply_reset();
        cfg_write(4'd2, 1'b1, 16'd100, 32'd3);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (val !== 1'b1 || str !== 4'd2 || size !== 16'd100 || done[2] !== 1'b0) begin errors++;
                $display("FAIL stall_hold%0d: val %b str %0d size %0d done %b expected 1/2/100/0",
                         c, val, str, size, done[2]); end
        end
        rd_req = 1'b1;
        n = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!val) break;
            n++;
        end
        rd_req = 1'b0;
        run = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL stall_budget: got %0d tasks expected 3", n); end
        checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", done[2]); end
    endtask

    task automatic test_size_zero();
        apply_reset();
        cfg_write(4'd4, 1'b1, 16'd0, 32'd0);
        run = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL size0_val: got %b expected 0", val); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL size0_busy: got %b expected 0", busy); end
        run = 1'b0;
    endtask

    task automatic test_rd_empty();
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (val !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rd_empty: val %b busy %b expected 0/0", val, busy); end
    endtask

    task automatic test_cfg_collide();
        int n;
        apply_reset();
        cfg_write(4'd6, 1'b1, 16'd8, 32'd1);
        @(posedge clk); #1;
        run = 1'b1;
        cfg_wr = 1'b1; cfg_flow = 4'd6; cfg_en = 1'b1; cfg_size = 16'd99; cfg_cnt = 32'd5;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        @(negedge clk);
        checks++; if (val !== 1'b1 || str !== 4'd6 || size !== 16'd8) begin errors++;
            $display("FAIL collide_first: val %b str %0d size %0d expected 1/6/8", val, str, size); end
        rd_req = 1'b1;
        n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!val) break;
            n++;
            checks++; if (size !== 16'd99) begin errors++;
                $display("FAIL collide_size%0d: got %0d expected 99", n, size); end
        end
        rd_req = 1'b0;
        run = 1'b0;
        checks++; if (n != 6) begin errors++; $display("FAIL collide_count: got %0d tasks expected 6", n); end
        checks++; if (done[6] !== 1'b1) begin errors++; $display("FAIL collide_done: got %b expected 1", done[6]); end
    endtask

    task automatic test_run_drop();
        apply_reset();
        cfg_write(4'd1, 1'b1, 16'd33, 32'd0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        checks++; if (val !== 1'b1 || str !== 4'd1 || size !== 16'd33) begin errors++;
            $display("FAIL rundrop_grant: val %b str %0d size %0d expected 1/1/33", val, str, size); end
        repeat (3) @(negedge clk);
        checks++; if (val !== 1'b1 || str !== 4'd1) begin errors++;
            $display("FAIL rundrop_hold: val %b str %0d expected 1/1", val, str); end
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        checks++; if (val !== 1'b0) begin errors++; $display("FAIL rundrop_empty: val got %b expected 0", val); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rundrop_busy: got %b expected 1", busy); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cfg_write(4'd7, 1'b1, 16'd70, 32'd0);
        cfg_write(4'd0, 1'b1, 16'd7, 32'd0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (val !== 1'b0 || str !== 4'd0 || size !== 16'd0 || busy !== 1'b0 || done !== 16'h0) begin errors++;
            $display("FAIL midreset_async: val %b str %0d size %0d busy %b done %h expected all 0",
                     val, str, size, busy, done); end
        rd_req = 1'b0; run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_write(4'd7, 1'b1, 16'd70, 32'd0);
        cfg_write(4'd0, 1'b1, 16'd7, 32'd0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        checks++; if (val !== 1'b1 || str !== 4'd0 || size !== 16'd7) begin errors++;
            $display("FAIL midreset_first: val %b str %0d size %0d expected 1/0/7", val, str, size); end
    endtask

`ifdef PKT_TASK_SCHED_STAT_EN
    task automatic test_stat();
        int n;
        apply_reset();
        stat_flow = 4'd2;
        cfg_write(4'd2, 1'b1, 16'd5, 32'd7);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!val) break;
            n++;
            @(negedge clk);
        end
        rd_req = 1'b0;
        run = 1'b0;
        checks++; if (n != 7) begin errors++; $display("FAIL stat_tasks: got %0d expected 7", n); end
        @(negedge clk);
        checks++; if (stat_cnt !== 32'd7) begin errors++; $display("FAIL stat_count: got %0d expected 7", stat_cnt); end
        cfg_write(4'd2, 1'b0, 16'd5, 32'd7);
        @(posedge clk);
        @(negedge clk);
        checks++; if (stat_cnt !== 32'd0) begin errors++; $display("FAIL stat_clear: got %0d expected 0", stat_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_flow();
        test_round_robin();
        test_stall();
        test_size_zero();
        test_rd_empty();
        test_cfg_collide();
        test_run_drop();
        test_reset_mid();
`ifdef PKT_TASK_SCHED_STAT_EN
        test_stat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_task_sched.md
Name: pkt_task_sched

Overview:
- Per-flow task scheduler that feeds the task interface of the packet generator (`pkt_task_str/size/val`, `pkt_task_rd_req`).
- Holds per-flow configuration: enable, packet size and packet budget.
- Arbitrates round-robin among eligible flows and presents one committed task at a time in a show-ahead output stage.
- Sits between the CSR/control logic and the generator; flows run until their budget is exhausted or they are disabled.

Parameters:
- FLOW_CNT, 16, number of flows.
- FLOW_CNT_WIDTH, (FLOW_CNT==1) ? 1 : $clog2(FLOW_CNT), flow index width.
- CNT_WIDTH, 32, width of the per-flow packet budget counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- run_i  in  1  level; new grants are made only while high.
- cfg_wr_i  in  1  one-cycle flow config write strobe.
- cfg_flow_i  in  FLOW_CNT_WIDTH  flow index for the write.
- cfg_en_i  in  1  flow enable.
- cfg_size_i  in  16  packet size in bytes.
- cfg_pkt_cnt_i  in  CNT_WIDTH  packet budget; 0 = unlimited.
- pkt_task_str_o  out  FLOW_CNT_WIDTH  flow of the presented task.
- pkt_task_size_o  out  16  size of the presented task.
- pkt_task_val_o  out  1  task stage holds a task.
- pkt_task_rd_req_i  in  1  generator consumes the presented task this cycle.
- flow_done_o  out  FLOW_CNT  per-flow: enabled, finite budget, remaining==0, not in stage.
- busy_o  out  1  stage valid or any flow eligible.

Behaviour:
- Reset values: all outputs 0; all flow enables 0; sizes 0; remaining counts 0; unlimited flags 0; RR pointer = FLOW_CNT-1, so flow 0 wins first; stage empty.
- Eligibility of flow i: en && size!=0 && (unlimited || remaining!=0). A flow with size 0 is never granted.
- Arbiter:
  - Combinational round-robin search from pointer+1, wrapping at FLOW_CNT-1 -> 0.
  - Grant condition: run_i && eligible!=0 && (stage empty || rd_req_i).
  - On grant at edge N: stage <= {winner, size[winner]}; pointer <= winner; remaining[winner] decremented unless unlimited. pkt_task_val_o is high from N+1.
  - The budget is charged at grant time. A task in the stage is committed and is not revoked by a later disable or config write; it is delivered with its latched size.
- Stage FSM has two states:
  - EMPTY -> FULL on grant.
  - FULL -> FULL on rd_req with a grant (back-to-back, val stays 1, new task visible the next cycle).
  - FULL -> EMPTY on rd_req without a grant.
  - FULL holds while rd_req is low.
- rd_req_i while the stage is EMPTY is ignored; the simulation assertion flags it.
- Latency: config write to first val_o is 2 cycles (write edge, grant edge). Sustained throughput is one task per cycle if rd_req_i is held high.
- Config write: at the edge, en/size/unlimited/remaining[flow] <= inputs, with remaining = cfg_pkt_cnt_i.
  - A write to the flow being granted in the same cycle takes precedence over that grant's decrement (the written count stands).
  - The grant itself still uses the pre-write size.
- run_i deassert: no new grants; a FULL stage is still presented and consumable.
- Single-flow, or only one eligible flow: that flow is re-granted every time.
- Reset mid-operation: the stage and all flow state clear immediately; val_o drops asynchronously.

Optional Feature:
- Macro: PKT_TASK_SCHED_STAT_EN.
- When defined, adds ports stat_flow_i (in, FLOW_CNT_WIDTH) and stat_pkt_cnt_o (out, 32). stat_pkt_cnt_o is a registered read, 1-cycle latency, of a per-flow counter of consumed tasks (incremented on rd_req_i for pkt_task_str_o).
- Counters wrap at 2^32, clear on reset and on a cfg_wr_i to that flow.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pkt_task_sched_pkg: flow_cfg_t struct {en, unlimited, size[15:0], remaining[CNT_WIDTH-1:0]} and a task_t struct {str, size}.
- Sub-module rr_arbiter (parameter N): request vector, pointer and advance in; one-hot grant plus index out; purely combinational plus the pointer register.

Test Plan:
- Single flow: flow 3 en, size 64, cnt 2, run_i=1, rd_req held high -> val_o for exactly 2 tasks {str 3, size 64}, then val_o=0, flow_done_o[3]=1.
- Round robin: flows 0, 1, 5 en, unlimited, rd_req high -> str sequence 0,1,5,0,1,5 with val_o continuous after the first grant.
- Stall: rd_req low for 10 cycles with the stage FULL -> str/size stable, no counter decrement; remaining budget unchanged except for the one committed grant.
- Boundaries:
  - size 0 flow enabled -> never granted.
  - Config write of cnt 5 to the flow granted that cycle -> remaining reads 5.
  - rd_req while EMPTY -> ignored, assertion fires.
- run_i/reset: drop run_i with stage FULL -> that task is still consumed, then val_o=0. Assert rst_n_i mid-stream -> all outputs 0 asynchronously; after release, flow 0 is granted first.
- STAT_EN: 7 tasks consumed on flow 2 -> stat_pkt_cnt_o=7 one cycle after stat_flow_i=2; a cfg write to flow 2 clears it to 0.
